// File: rtl/pia_multi_pkg.sv
// Shared constants, CR bit map, C2 mode encoding and address helpers for the
// multi-port PIA core.
package pia_multi_pkg;

    localparam int DATA_WIDTH = 8;

    // Control register bit positions
    localparam int PIA_CR_C1_EN       = 0;
    localparam int PIA_CR_C1_EDGE     = 1;
    localparam int PIA_CR_PIB_SEL     = 2;
    localparam int PIA_CR_C2_MODE_LSB = 3;
    localparam int PIA_CR_C2_FLAG     = 6;
    localparam int PIA_CR_C1_FLAG     = 7;

    // CR[5:3]: 0xy = input (x edge, y irq enable), 100 handshake, 101 pulse, 11z manual
    typedef enum logic [2:0] {
        C2_IN_FALL     = 3'b000,
        C2_IN_FALL_IRQ = 3'b001,
        C2_IN_RISE     = 3'b010,
        C2_IN_RISE_IRQ = 3'b011,
        C2_HANDSHAKE   = 3'b100,
        C2_PULSE       = 3'b101,
        C2_MANUAL_LO   = 3'b110,
        C2_MANUAL_HI   = 3'b111
    } c2_mode_e;

    typedef enum logic {
        C2_IDLE = 1'b0,
        C2_LOW  = 1'b1
    } c2_state_e;

    // Bits needed to hold the value n (at least 1)
    function automatic int bit_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

    // Register-select value for a given port and sel (0 = DDR/PIB, 1 = CR)
    function automatic int pia_rs(input int port, input bit sel);
        return port * 2 + int'(sel);
    endfunction

endpackage

// File: rtl/pia_multi_port.sv
// One PIA port: DDR/OR/CR registers, C1/C2 synchronisers and edge flags,
// combinational read mux and the C2 output state machine.
module pia_port
    import pia_multi_pkg::*;
#(
    parameter int PORT_WIDTH = 8,
    parameter bit ODD_PORT   = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  acc_i,
    input  logic                  we_i,
    input  logic                  sel_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    input  logic [PORT_WIDTH-1:0] port_i,
    output logic [PORT_WIDTH-1:0] port_o,
    output logic [PORT_WIDTH-1:0] port_oe_o,
    input  logic                  c1_i,
    input  logic                  c2_i,
    output logic                  c2_o,
    output logic                  c2_oe_o,
    output logic                  irq_o
);

    localparam int ML = PIA_CR_C2_MODE_LSB;

    logic [PORT_WIDTH-1:0] ddr_q, ddr_d, or_q, or_d;
    logic [PORT_WIDTH-1:0] pin_s1_q, pin_s2_q;
    logic [7:0]            cr_q, cr_d;
    logic [2:0]            c1_sync_q, c2_sync_q;
    c2_state_e             st_q;
    logic                  c2_q;

    logic      rd, wr, pib_rd, pib_wr, trig;
    logic      c1_edge, c2_edge, mode_chg;
    c2_mode_e  mode_d;

    // Access decode, edge detection and next-state of the register file
    always_comb begin
        rd     = acc_i & ~we_i;
        wr     = acc_i & we_i;
        pib_rd = rd & ~sel_i & cr_q[PIA_CR_PIB_SEL];
        pib_wr = wr & ~sel_i & cr_q[PIA_CR_PIB_SEL];
        trig   = ODD_PORT ? pib_wr : pib_rd;

        // [1] is the settled synchronised sample, [2] the one before it
        c1_edge = cr_q[PIA_CR_C1_EDGE] ? (c1_sync_q[1] & ~c1_sync_q[2])
                                       : (~c1_sync_q[1] & c1_sync_q[2]);
        // C2 flag only meaningful while C2 is an input
        c2_edge = ~cr_q[ML+2] & (cr_q[ML+1] ? (c2_sync_q[1] & ~c2_sync_q[2])
                                            : (~c2_sync_q[1] & c2_sync_q[2]));

        ddr_d = ddr_q;
        or_d  = or_q;
        if (wr && !sel_i) begin
            if (cr_q[PIA_CR_PIB_SEL]) or_d  = data_i[PORT_WIDTH-1:0];
            else                      ddr_d = data_i[PORT_WIDTH-1:0];
        end

        cr_d = cr_q;
        if (wr && sel_i) cr_d[5:0] = data_i[5:0];
        // A new edge beats a same-cycle PIB read clear
        cr_d[PIA_CR_C1_FLAG] = c1_edge | (cr_q[PIA_CR_C1_FLAG] & ~pib_rd);
        cr_d[PIA_CR_C2_FLAG] = c2_edge | (cr_q[PIA_CR_C2_FLAG] & ~pib_rd);

        mode_d   = c2_mode_e'(cr_d[ML+2:ML]);
        mode_chg = wr & sel_i & (cr_d[ML+2:ML] != cr_q[ML+2:ML]);
    end

    // Read data for the top-level mux; zero-extended above PORT_WIDTH
    always_comb begin
        rdata_o = '0;
        if (sel_i)
            rdata_o = cr_q;
        else if (cr_q[PIA_CR_PIB_SEL])
            rdata_o[PORT_WIDTH-1:0] = (or_q & ddr_q) | (pin_s2_q & ~ddr_q);
        else
            rdata_o[PORT_WIDTH-1:0] = ddr_q;
    end

    // Register file
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ddr_q <= '0;
            or_q  <= '0;
            cr_q  <= '0;
        end else begin
            ddr_q <= ddr_d;
            or_q  <= or_d;
            cr_q  <= cr_d;
        end
    end

    // Two-flop synchronisers plus one history flop for edge detection
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pin_s1_q  <= '0;
            pin_s2_q  <= '0;
            c1_sync_q <= '0;
            c2_sync_q <= '0;
        end else begin
            pin_s1_q  <= port_i;
            pin_s2_q  <= pin_s1_q;
            c1_sync_q <= {c1_sync_q[1:0], c1_i};
            c2_sync_q <= {c2_sync_q[1:0], c2_i};
        end
    end

    // C2 output FSM: manual follows CR[3]; handshake/pulse drop low on trigger
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            st_q <= C2_IDLE;
            c2_q <= 1'b1;
        end else if (mode_d == C2_MANUAL_LO || mode_d == C2_MANUAL_HI) begin
            st_q <= C2_IDLE;
            c2_q <= cr_d[ML];
        end else if (!cr_d[ML+2] || mode_chg) begin
            st_q <= C2_IDLE;
            c2_q <= 1'b1;
        end else if (trig) begin
            st_q <= C2_LOW;
            c2_q <= 1'b0;
        end else if (st_q == C2_LOW && (mode_d == C2_PULSE || c1_edge)) begin
            st_q <= C2_IDLE;
            c2_q <= 1'b1;
        end
    end

    assign port_o    = or_q;
    assign port_oe_o = ddr_q;
    assign c2_o      = c2_q;
    assign c2_oe_o   = cr_q[ML+2];
    assign irq_o     = (cr_q[PIA_CR_C1_FLAG] & cr_q[PIA_CR_C1_EN])
                     | (cr_q[PIA_CR_C2_FLAG] & cr_q[ML] & ~cr_q[ML+2]);

endmodule

// File: rtl/pia_multi.sv
// Multi-port PIA top: register-select decode, per-port instances and the
// registered read-data mux.
module pia_multi
    import pia_multi_pkg::*;
#(
    parameter  int NUM_PORTS  = 2,
    parameter  int PORT_WIDTH = 8,
    localparam int RS_WIDTH   = bit_width(2 * NUM_PORTS - 1)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [RS_WIDTH-1:0]             rs_i,
    input  logic [DATA_WIDTH-1:0]           data_i,
    input  logic                            we_i,
    input  logic                            strobe_i,
    output logic [DATA_WIDTH-1:0]           data_o,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0] port_i,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] port_o,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] port_oe_o,
    input  logic [NUM_PORTS-1:0]            c1_i,
    input  logic [NUM_PORTS-1:0]            c2_i,
    output logic [NUM_PORTS-1:0]            c2_o,
    output logic [NUM_PORTS-1:0]            c2_oe_o,
    output logic [NUM_PORTS-1:0]            irq_o
);

    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata;
    logic [NUM_PORTS-1:0]                 acc;
    logic [DATA_WIDTH-1:0]                rd_mux, data_q;
    int                                   port_sel;

    // Upper rs_i bits pick the port; indices >= NUM_PORTS select nothing
    assign port_sel = int'(32'(rs_i) >> 1);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign acc[p] = strobe_i & (port_sel == p);

        pia_port #(
            .PORT_WIDTH (PORT_WIDTH),
            .ODD_PORT   (1'(p % 2))
        ) u_port (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .acc_i     (acc[p]),
            .we_i      (we_i),
            .sel_i     (rs_i[0]),
            .data_i    (data_i),
            .rdata_o   (rdata[p]),
            .port_i    (port_i[p*PORT_WIDTH +: PORT_WIDTH]),
            .port_o    (port_o[p*PORT_WIDTH +: PORT_WIDTH]),
            .port_oe_o (port_oe_o[p*PORT_WIDTH +: PORT_WIDTH]),
            .c1_i      (c1_i[p]),
            .c2_i      (c2_i[p]),
            .c2_o      (c2_o[p]),
            .c2_oe_o   (c2_oe_o[p]),
            .irq_o     (irq_o[p])
        );
    end

    // Read mux; out-of-range port reads as zero
    always_comb begin
        rd_mux = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            if (port_sel == p) rd_mux = rdata[p];
    end

    // Read data register, updated only on read strobes
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)                data_q <= '0;
        else if (strobe_i && !we_i) data_q <= rd_mux;
    end

    assign data_o = data_q;

endmodule
